// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the fetch port and the data port, one transaction at a time.
// Data requests win over fetches; fetch responses cancelled by a pipeline flush are swallowed.
module sram_bus_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        inst_cancel,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata,
   output logic [1:0]  dbgState
);

   // Handshakes: a requester holds req and its fields until the cycle its addr_ok is high;
   // mem_req stays high with stable fields until mem_addr_ok; each *_ok is a single-cycle pulse.
   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} arbStateT;
   typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} ownerT;

   arbStateT    state;
   arbStateT    nextState;
   ownerT       owner;
   logic        cancelPending;
   logic        grant;
   logic        grantData;
   logic        addrAccept;
   logic        respDone;
   logic        latWr;
   logic [1:0]  latSize;
   logic [31:0] latAddr;
   logic [31:0] latWdata;

   always_comb begin
      nextState = state;
      grant     = 1'b0;
      grantData = 1'b0;
      case (state)
         IDLE: grant = inst_req | data_req;
         ADDR: if (mem_addr_ok) nextState = DATA;
         DATA: begin
            if (mem_data_ok) begin
               grant     = inst_req | data_req;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
      // A response edge can also take the next grant, so the bus never idles between them.
      if (grant) begin
         nextState = ADDR;
         grantData = data_req;
      end
   end

   assign addrAccept = (state == ADDR) && mem_addr_ok;
   assign respDone   = (state == DATA) && mem_data_ok;

   assign inst_addr_ok = addrAccept && (owner == OWN_INST);
   assign data_addr_ok = addrAccept && (owner == OWN_DATA);
   assign inst_data_ok = respDone && (owner == OWN_INST) && !cancelPending;
   assign data_data_ok = respDone && (owner == OWN_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   assign mem_req   = (state == ADDR);
   assign mem_wr    = latWr;
   assign mem_size  = latSize;
   assign mem_addr  = latAddr;
   assign mem_wdata = latWdata;
   assign dbgState  = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         owner         <= OWN_INST;
         cancelPending <= 1'b0;
         latWr         <= 1'b0;
         latSize       <= 2'd0;
         latAddr       <= 32'd0;
         latWdata      <= 32'd0;
      end else begin
         state <= nextState;
         if (grant) begin
            owner    <= grantData ? OWN_DATA : OWN_INST;
            latWr    <= grantData ? data_wr : 1'b0;
            latSize  <= grantData ? data_size : 2'd2;
            latAddr  <= grantData ? data_addr : inst_addr;
            latWdata <= grantData ? data_wdata : 32'd0;
         end
         // Clearing wins: a cancel landing on the response cycle cannot poison the next fetch.
         if (respDone)
            cancelPending <= 1'b0;
         else if (inst_cancel && (owner == OWN_INST) && ((state == DATA) || addrAccept))
            cancelPending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed scenarios for the arbiter followed by a randomized run against a
// transaction-level model of the shared bus, the two requesters and the memory.
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_cancel;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;
   logic [1:0]  dbgState;

   sram_bus_arbiter dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
      .dbgState(dbgState)
   );

   always #5 clk = ~clk;

   int numChecks = 0;
   int numErrors = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      numChecks++;
      if (got !== exp) begin
         numErrors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memData(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
   endfunction

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic clearInputs();
      inst_req = 1'b0; inst_addr = 32'd0; inst_cancel = 1'b0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'd0;
   endtask

   // Random-phase model: bus phase 0 free, 1 address offered, 2 awaiting data.
   int          phase;
   bit          ownerData;
   logic [31:0] busAddr, busWdata;
   logic        busWr;
   logic [1:0]  busSize;
   int          addrWait, dataWait;
   bit          cancelNow, allowNew, respond, anyReq, expInstOk, expDataOk, expCan, expLoad;
   bit          instPend, dataPend;
   logic [31:0] instA, dA, dWd, expR;
   logic        dW;
   logic [1:0]  dS;
   logic [31:0] instExpQ[$];
   logic [31:0] dataExpQ[$];
   bit          instCanQ[$];
   bit          dataLoadQ[$];

   task automatic grantNext();
      ownerData = dataPend;
      if (dataPend) begin
         busAddr = dA; busWr = dW; busSize = dS; busWdata = dWd;
      end else begin
         busAddr = instA; busWr = 1'b0; busSize = 2'd2; busWdata = 32'd0;
      end
      addrWait = $urandom_range(0, 3);
      phase = 1;
   endtask

   initial begin
      clearInputs();
      rst = 1'b1;
      #1 rst = 1'b0;
      mem_addr_ok = 1'b1;
      mem_data_ok = 1'b1;
      #12;
      checkVal("rst_mem_req", 32'(mem_req), 32'd0);
      checkVal("rst_mem_wr", 32'(mem_wr), 32'd0);
      checkVal("rst_mem_size", 32'(mem_size), 32'd0);
      checkVal("rst_mem_addr", mem_addr, 32'd0);
      checkVal("rst_mem_wdata", mem_wdata, 32'd0);
      checkVal("rst_oks", 32'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}), 32'd0);
      nextCycle();
      clearInputs();
      rst = 1'b1;

      // Single fetch with immediate memory.
      nextCycle(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; settle();
      checkVal("fetch_idle_req", 32'(mem_req), 32'd0);
      nextCycle(); mem_addr_ok = 1'b1; settle();
      checkVal("fetch_mem_req", 32'(mem_req), 32'd1);
      checkVal("fetch_mem_addr", mem_addr, 32'hBFC0_0000);
      checkVal("fetch_mem_wr", 32'(mem_wr), 32'd0);
      checkVal("fetch_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      checkVal("fetch_data_addr_ok", 32'(data_addr_ok), 32'd0);
      nextCycle(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h3C08_0001; settle();
      checkVal("fetch_inst_data_ok", 32'(inst_data_ok), 32'd1);
      checkVal("fetch_inst_rdata", inst_rdata, 32'h3C08_0001);
      checkVal("fetch_data_data_ok", 32'(data_data_ok), 32'd0);
      checkVal("fetch_req_drop", 32'(mem_req), 32'd0);
      nextCycle(); mem_data_ok = 1'b0; settle();
      checkVal("fetch_back_idle", 32'(mem_req), 32'd0);

      // Contention: the store wins, the fetch follows with no idle cycle.
      nextCycle();
      inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
      nextCycle(); mem_addr_ok = 1'b1; settle();
      checkVal("cont_mem_wr", 32'(mem_wr), 32'd1);
      checkVal("cont_mem_size", 32'(mem_size), 32'd2);
      checkVal("cont_mem_addr", mem_addr, 32'h8000_0010);
      checkVal("cont_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      checkVal("cont_data_addr_ok", 32'(data_addr_ok), 32'd1);
      checkVal("cont_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      nextCycle(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; settle();
      checkVal("cont_data_data_ok", 32'(data_data_ok), 32'd1);
      checkVal("cont_inst_data_ok", 32'(inst_data_ok), 32'd0);
      nextCycle(); mem_data_ok = 1'b0; mem_addr_ok = 1'b1; settle();
      checkVal("cont_no_gap", 32'(mem_req), 32'd1);
      checkVal("cont_fetch_addr", mem_addr, 32'hBFC0_0004);
      checkVal("cont_fetch_wr", 32'(mem_wr), 32'd0);
      checkVal("cont_fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
      nextCycle(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = memData(32'hBFC0_0004); settle();
      checkVal("cont_fetch_data_ok", 32'(inst_data_ok), 32'd1);
      checkVal("cont_fetch_rdata", inst_rdata, memData(32'hBFC0_0004));
      nextCycle(); clearInputs();

      // Slow memory: latched fields hold while the requester's inputs wander.
      nextCycle(); data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_addr = 32'h8000_0040; data_wdata = 32'h1234_5678;
      for (int i = 0; i < 3; i++) begin
         nextCycle(); data_addr = $urandom; data_wdata = $urandom; settle();
         checkVal("slow_mem_addr", mem_addr, 32'h8000_0040);
         checkVal("slow_mem_wdata", mem_wdata, 32'h1234_5678);
         checkVal("slow_addr_ok", 32'(data_addr_ok), 32'd0);
      end
      nextCycle(); mem_addr_ok = 1'b1; settle();
      checkVal("slow_final_addr", mem_addr, 32'h8000_0040);
      checkVal("slow_data_addr_ok", 32'(data_addr_ok), 32'd1);
      nextCycle(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; settle();
      checkVal("slow_data_data_ok", 32'(data_data_ok), 32'd1);
      nextCycle(); clearInputs();

      // Cancel in the data phase, then a normal fetch.
      nextCycle(); inst_req = 1'b1; inst_addr = 32'hBFC0_0008;
      nextCycle(); mem_addr_ok = 1'b1; settle();
      checkVal("cancel_addr_ok", 32'(inst_addr_ok), 32'd1);
      nextCycle(); inst_req = 1'b0; mem_addr_ok = 1'b0; inst_cancel = 1'b1;
      nextCycle(); inst_cancel = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0BAD_0BAD; settle();
      checkVal("cancel_suppressed", 32'(inst_data_ok), 32'd0);
      nextCycle(); mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'hBFC0_000C;
      nextCycle(); mem_addr_ok = 1'b1;
      nextCycle(); inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = memData(32'hBFC0_000C); settle();
      checkVal("after_cancel_ok", 32'(inst_data_ok), 32'd1);
      checkVal("after_cancel_rdata", inst_rdata, memData(32'hBFC0_000C));
      nextCycle(); clearInputs();

      // Byte load.
      nextCycle(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h8000_0003;
      nextCycle(); mem_addr_ok = 1'b1; settle();
      checkVal("byte_mem_size", 32'(mem_size), 32'd0);
      checkVal("byte_mem_addr", mem_addr, 32'h8000_0003);
      checkVal("byte_mem_wr", 32'(mem_wr), 32'd0);
      nextCycle(); data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h0000_00AB; settle();
      checkVal("byte_data_ok", 32'(data_data_ok), 32'd1);
      checkVal("byte_rdata", data_rdata, 32'h0000_00AB);
      nextCycle(); clearInputs();

      // Reset while waiting for data; a late response afterwards is dropped.
      nextCycle(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h8000_0006;
      nextCycle(); mem_addr_ok = 1'b1;
      nextCycle(); data_req = 1'b0; mem_addr_ok = 1'b0; settle();
      rst = 1'b0;
      #1;
      checkVal("mid_rst_mem_addr", mem_addr, 32'd0);
      checkVal("mid_rst_mem_size", 32'(mem_size), 32'd0);
      checkVal("mid_rst_mem_req", 32'(mem_req), 32'd0);
      nextCycle(); nextCycle(); rst = 1'b1;
      nextCycle(); mem_data_ok = 1'b1; mem_rdata = 32'h5555_AAAA; settle();
      checkVal("late_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
      nextCycle(); clearInputs();

      // Randomized traffic against the transaction-level model.
      phase = 0; ownerData = 1'b0; cancelNow = 1'b0; instPend = 1'b0; dataPend = 1'b0;
      addrWait = 0; dataWait = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         allowNew = (cyc < 2800);
         nextCycle();
         if (!instPend && allowNew && $urandom_range(0, 3) == 0) begin
            instPend = 1'b1; instA = $urandom & 32'hFFFF_FFFC;
         end
         if (!dataPend && allowNew && $urandom_range(0, 3) == 0) begin
            dataPend = 1'b1; dW = 1'($urandom_range(0, 1)); dS = 2'($urandom_range(0, 2));
            dA = $urandom; dWd = $urandom;
         end
         inst_req    = instPend;
         inst_addr   = instPend ? instA : $urandom;
         data_req    = dataPend;
         data_wr     = dataPend ? dW : 1'($urandom);
         data_size   = dataPend ? dS : 2'($urandom);
         data_addr   = dataPend ? dA : $urandom;
         data_wdata  = dataPend ? dWd : $urandom;
         inst_cancel = cancelNow;
         respond     = (phase == 2) && (dataWait == 0);
         mem_addr_ok = (phase == 1) && (addrWait == 0);
         mem_data_ok = respond || ((phase != 2) && ($urandom_range(0, 7) == 0));
         mem_rdata   = respond ? memData(busAddr) : $urandom;
         settle();

         checkVal("rnd_mem_req", 32'(mem_req), 32'(phase == 1));
         if (phase == 1) begin
            checkVal("rnd_mem_addr", mem_addr, busAddr);
            checkVal("rnd_mem_wr", 32'(mem_wr), 32'(busWr));
            checkVal("rnd_mem_size", 32'(mem_size), 32'(busSize));
            if (busWr) checkVal("rnd_mem_wdata", mem_wdata, busWdata);
         end
         checkVal("rnd_inst_addr_ok", 32'(inst_addr_ok), 32'(mem_addr_ok && !ownerData));
         checkVal("rnd_data_addr_ok", 32'(data_addr_ok), 32'(mem_addr_ok && ownerData));
         expInstOk = 1'b0;
         expDataOk = 1'b0;
         if (respond && !ownerData && instExpQ.size() > 0) begin
            expR = instExpQ.pop_front();
            expCan = instCanQ.pop_front();
            expInstOk = !expCan;
            if (expInstOk) checkVal("rnd_inst_rdata", inst_rdata, expR);
         end else if (respond && ownerData && dataExpQ.size() > 0) begin
            expR = dataExpQ.pop_front();
            expLoad = dataLoadQ.pop_front();
            expDataOk = 1'b1;
            if (expLoad) checkVal("rnd_data_rdata", data_rdata, expR);
         end
         checkVal("rnd_inst_data_ok", 32'(inst_data_ok), 32'(expInstOk));
         checkVal("rnd_data_data_ok", 32'(data_data_ok), 32'(expDataOk));

         anyReq = instPend || dataPend;
         cancelNow = 1'b0;
         case (phase)
            0: if (anyReq) grantNext();
            1: begin
               if (mem_addr_ok) begin
                  if (!ownerData) begin
                     instPend = 1'b0;
                     instExpQ.push_back(memData(busAddr));
                     cancelNow = ($urandom_range(0, 2) == 0);
                     instCanQ.push_back(cancelNow);
                  end else begin
                     dataPend = 1'b0;
                     dataExpQ.push_back(memData(busAddr));
                     dataLoadQ.push_back(!busWr);
                  end
                  phase = 2;
                  dataWait = $urandom_range(cancelNow ? 1 : 0, 3);
               end else begin
                  addrWait--;
               end
            end
            default: begin
               if (respond) begin
                  if (anyReq) grantNext();
                  else phase = 0;
               end else begin
                  dataWait--;
               end
            end
         endcase
      end

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule
